// File: rtl/sqrt_pkg.sv
// Shared width helpers for the streaming square-root pipeline.
// Build option: SQRT_ROUND_EN adds a round-to-nearest guard stage.
package sqrt_pkg;

    function automatic int int_bits(input int ib);
        return (ib + 1) / 2;
    endfunction

    function automatic int out_bits(input int ib, input int fb);
        return int_bits(ib) + fb;
    endfunction

    function automatic int work_bits(input int ib, input int fb);
        return ib + 2 * fb;
    endfunction

    // Payload = valid + rem(2*ob) + root(ob+1, LSB is guard) + tag
    function automatic int pay_bits(input int ob, input int tb);
        return 1 + 2 * ob + (ob + 1) + tb;
    endfunction

endpackage

// File: rtl/sqrt_pipelined_stream_if.sv
// Valid/ready stream bundle for the square-root pipeline.
// Build option: SQRT_ROUND_EN (no effect on this bundle's shape).
interface sqrt_pipelined_stream_if
    import sqrt_pkg::*;
#(
    parameter int INPUT_BITS = 16,
    parameter int FRAC_BITS  = 0,
    parameter int TAG_BITS   = 4
);
    localparam int OUTPUT_BITS = out_bits(INPUT_BITS, FRAC_BITS);
    localparam int REM_BITS    = OUTPUT_BITS + 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [INPUT_BITS-1:0]  radicand;
    logic [TAG_BITS-1:0]    in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUTPUT_BITS-1:0] root;
    logic [REM_BITS-1:0]    remainder;
    logic [TAG_BITS-1:0]    out_tag;

    modport slave (
        input  in_valid, radicand, in_tag, out_ready,
        output in_ready, out_valid, root, remainder, out_tag
    );

    modport master (
        output in_valid, radicand, in_tag, out_ready,
        input  in_ready, out_valid, root, remainder, out_tag
    );

endinterface

// File: rtl/sqrt_stage.sv
// One restoring-sqrt trial-subtract stage with hold enable.
// STAGE_IDX == OB is the guard stage used under SQRT_ROUND_EN.
module sqrt_stage
    import sqrt_pkg::*;
#(
    parameter int OB        = 8,
    parameter int TB        = 4,
    parameter int STAGE_IDX = 0,
    localparam int PB       = pay_bits(OB, TB)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_en,
    input  logic [PB-1:0] i_pl,
    output logic [PB-1:0] o_pl
);
    localparam int RW = 2 * OB;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rem;
        logic [OB:0]   root;
        logic [TB-1:0] tag;
    } pl_t;

    pl_t w_in;
    pl_t w_nxt;
    pl_t r_pl;

    assign w_in = i_pl;

    if (STAGE_IDX < OB) begin : g_bit
        localparam int J = OB - 1 - STAGE_IDX;
        logic [RW-1:0] w_trial;

        // (4*r + 1) << 2j with r the root bits already decided
        assign w_trial = (RW'(w_in.root[OB:1]) << (J + 1))
                       | (RW'(1) << (2 * J));

        // Keep the bit if the trial square still fits
        always_comb begin
            w_nxt = w_in;
            if (w_in.rem >= w_trial) begin
                w_nxt.rem         = w_in.rem - w_trial;
                w_nxt.root[J + 1] = 1'b1;
            end
        end
    end else begin : g_guard
        // Half-LSB bit: (r+0.5)^2 <= x  <=>  rem > r
        always_comb begin
            w_nxt         = w_in;
            w_nxt.root[0] = (w_in.rem > RW'(w_in.root[OB:1]));
        end
    end

    // Stage slot register, frozen while downstream stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pl <= '0;
        end else if (i_en) begin
            r_pl <= w_nxt;
        end
    end

    assign o_pl = r_pl;

endmodule

// File: rtl/sqrt_pipelined_stream.sv
// Streaming fixed-point square root with valid/ready backpressure.
// Build option: SQRT_ROUND_EN -> extra guard stage, round to nearest.
module sqrt_pipelined_stream
    import sqrt_pkg::*;
#(
    parameter int INPUT_BITS = 16,
    parameter int FRAC_BITS  = 0,
    parameter int TAG_BITS   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    sqrt_pipelined_stream_if.slave bus
);
    localparam int OB = out_bits(INPUT_BITS, FRAC_BITS);
    localparam int WB = work_bits(INPUT_BITS, FRAC_BITS);
    localparam int RW = 2 * OB;
    localparam int RB = OB + 1;
    localparam int PB = pay_bits(OB, TAG_BITS);
`ifdef SQRT_ROUND_EN
    localparam int NST = OB + 1;
`else
    localparam int NST = OB;
`endif

    typedef struct packed {
        logic                valid;
        logic [RW-1:0]       rem;
        logic [OB:0]         root;
        logic [TAG_BITS-1:0] tag;
    } pl_t;

    logic                w_adv;
    pl_t                 w_head;
    pl_t                 w_tail;
    logic [PB-1:0]       w_pl [0:NST];
    logic [OB-1:0]       w_trunc;
    logic [OB-1:0]       w_root;
    logic                w_unused_bits;
    logic                r_out_valid;
    logic [OB-1:0]       r_root;
    logic [RB-1:0]       r_rem;
    logic [TAG_BITS-1:0] r_tag;

    assign w_adv        = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_adv;

    // Scale radicand by 2^(2*FRAC_BITS) into the work field
    always_comb begin
        w_head       = '0;
        w_head.valid = bus.in_valid;
        w_head.rem   = RW'(bus.radicand) << (WB - INPUT_BITS);
        w_head.tag   = bus.in_tag;
    end

    assign w_pl[0] = w_head;

    for (genvar k = 0; k < NST; k++) begin : g_stage
        sqrt_stage #(
            .OB       (OB),
            .TB       (TAG_BITS),
            .STAGE_IDX(k)
        ) u_stage (
            .clk  (clk),
            .reset(reset),
            .i_en (w_adv),
            .i_pl (w_pl[k]),
            .o_pl (w_pl[k + 1])
        );
    end

    assign w_tail        = w_pl[NST];
    assign w_trunc       = w_tail.root[OB:1];
    assign w_unused_bits = ^{w_tail.rem, w_tail.root[0]};

`ifdef SQRT_ROUND_EN
    assign w_root = (&w_trunc) ? w_trunc
                  : w_trunc + OB'(w_tail.root[0]);
`else
    assign w_root = w_trunc;
`endif

    // Output register, holds while the consumer stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_root      <= '0;
            r_rem       <= '0;
            r_tag       <= '0;
        end else if (w_adv) begin
            r_out_valid <= w_tail.valid;
            r_root      <= w_root;
            r_rem       <= w_tail.rem[RB-1:0];
            r_tag       <= w_tail.tag;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.root      = r_root;
    assign bus.remainder = r_rem;
    assign bus.out_tag   = r_tag;

endmodule

// File: tb/tb_sqrt_pipelined_stream.sv
// Testbench for sqrt_pipelined_stream (16/0/4 and 16/4/4 instances).
// Honours SQRT_ROUND_EN in its expectations.
module tb_sqrt_pipelined_stream;

`ifdef SQRT_ROUND_EN
    localparam bit RND   = 1'b1;
    localparam int LAT_A = 10;
    localparam int LAT_B = 14;
`else
    localparam bit RND   = 1'b0;
    localparam int LAT_A = 9;
    localparam int LAT_B = 13;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sqrt_pipelined_stream_if #(.INPUT_BITS(16), .FRAC_BITS(0), .TAG_BITS(4)) ifa ();
    sqrt_pipelined_stream_if #(.INPUT_BITS(16), .FRAC_BITS(4), .TAG_BITS(4)) ifb ();

    sqrt_pipelined_stream #(.INPUT_BITS(16), .FRAC_BITS(0), .TAG_BITS(4)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave)
    );
    sqrt_pipelined_stream #(.INPUT_BITS(16), .FRAC_BITS(4), .TAG_BITS(4)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint isqrt(input longint x);
        longint r;
        r = longint'($sqrt(real'(x)));
        while (r * r > x) r--;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic longint ref_root(input longint x, input int ob);
        longint r;
        r = isqrt(x);
        if (RND && (4 * x > (2 * r + 1) * (2 * r + 1)) && (r < (longint'(1) << ob) - 1))
            r++;
        return r;
    endfunction

    typedef struct {
        logic [15:0] rad;
        logic [3:0]  tag;
        int          root;
        int          rem;
    } vec_t;

    typedef struct {
        int          root;
        int          rem;
        logic [3:0]  tag;
    } exp_t;

    task automatic op_a(input logic [15:0] rad, input logic [3:0] tag,
                        output logic [7:0] root, output logic [8:0] rem,
                        output logic [3:0] otag, output int lat);
        @(negedge clk);
        ifa.out_ready = 1'b1;
        ifa.in_valid  = 1'b1;
        ifa.radicand  = rad;
        ifa.in_tag    = tag;
        @(posedge clk);
        #1 ifa.in_valid = 1'b0;
        lat = 1;
        repeat (40) begin
            @(negedge clk);
            if (ifa.out_valid) break;
            @(posedge clk);
            lat++;
        end
        root = ifa.root;
        rem  = ifa.remainder;
        otag = ifa.out_tag;
    endtask

    task automatic op_b(input logic [15:0] rad, input logic [3:0] tag,
                        output logic [11:0] root, output logic [12:0] rem,
                        output logic [3:0] otag, output int lat);
        @(negedge clk);
        ifb.out_ready = 1'b1;
        ifb.in_valid  = 1'b1;
        ifb.radicand  = rad;
        ifb.in_tag    = tag;
        @(posedge clk);
        #1 ifb.in_valid = 1'b0;
        lat = 1;
        repeat (40) begin
            @(negedge clk);
            if (ifb.out_valid) break;
            @(posedge clk);
            lat++;
        end
        root = ifb.root;
        rem  = ifb.remainder;
        otag = ifb.out_tag;
    endtask

    task automatic stream_a(input string nm, input int n, input bit rnd,
                            input int stall_lo, input int stall_hi);
        exp_t        q[$];
        exp_t        e;
        int          sent, got, cyc;
        bit          have, p_stall;
        logic [15:0] rad;
        logic [3:0]  tg;
        logic [7:0]  p_root;
        logic [8:0]  p_rem;
        logic [3:0]  p_tag;
        longint      r;
        sent = 0; got = 0; cyc = 0; have = 0; p_stall = 0;
        rad = '0; tg = '0; p_root = '0; p_rem = '0; p_tag = '0;
        while (got < n && cyc < n * 6 + 200) begin
            @(negedge clk);
            if (!have && sent < n) begin
                rad  = rnd ? 16'($urandom) : 16'(sent);
                tg   = rnd ? 4'($urandom) : 4'(sent);
                have = 1'b1;
            end
            ifa.in_valid  = have && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            ifa.radicand  = rad;
            ifa.in_tag    = tg;
            ifa.out_ready = rnd ? ($urandom_range(0, 3) != 0)
                                : !(cyc >= stall_lo && cyc < stall_hi);
            #1;
            if (p_stall) begin
                check({nm, "_hold_valid"}, ifa.out_valid, 1);
                check({nm, "_hold_root"}, ifa.root, p_root);
                check({nm, "_hold_rem"}, ifa.remainder, p_rem);
                check({nm, "_hold_tag"}, ifa.out_tag, p_tag);
            end
            if (!rnd && !ifa.out_ready && ifa.out_valid)
                check({nm, "_in_ready_stall"}, ifa.in_ready, 0);
            if (ifa.out_valid && ifa.out_ready) begin
                if (q.size() == 0) begin
                    check({nm, "_unexpected_out"}, 1, 0);
                end else begin
                    e = q.pop_front();
                    check({nm, "_root"}, ifa.root, e.root);
                    check({nm, "_rem"}, ifa.remainder, e.rem);
                    check({nm, "_tag"}, ifa.out_tag, e.tag);
                end
                got++;
            end
            p_stall = ifa.out_valid && !ifa.out_ready;
            p_root  = ifa.root;
            p_rem   = ifa.remainder;
            p_tag   = ifa.out_tag;
            if (ifa.in_valid && ifa.in_ready) begin
                r      = isqrt(longint'(rad));
                e.root = int'(ref_root(longint'(rad), 8));
                e.rem  = int'(longint'(rad) - r * r);
                e.tag  = tg;
                q.push_back(e);
                sent++;
                have = 1'b0;
            end
            cyc++;
        end
        check({nm, "_count_out"}, got, n);
        check({nm, "_count_in_out"}, sent, got);
        @(negedge clk);
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[10];
        logic [7:0]  ra;
        logic [8:0]  ma;
        logic [11:0] rb;
        logic [12:0] mb;
        logic [3:0]  tg;
        int          lat, stale;

        ifa.in_valid = 0; ifa.radicand = '0; ifa.in_tag = '0; ifa.out_ready = 1;
        ifb.in_valid = 0; ifb.radicand = '0; ifb.in_tag = '0; ifb.out_ready = 1;

        #1;
        check("rst_a_valid", ifa.out_valid, 0);
        check("rst_a_root", ifa.root, 0);
        check("rst_a_rem", ifa.remainder, 0);
        check("rst_a_tag", ifa.out_tag, 0);
        check("rst_b_valid", ifb.out_valid, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        tbl[0] = '{16'd144,   4'd1,  12,           0};
        tbl[1] = '{16'd0,     4'd2,  0,            0};
        tbl[2] = '{16'd65535, 4'd3,  255,          510};
        tbl[3] = '{16'd49,    4'd4,  7,            0};
        tbl[4] = '{16'd2,     4'd5,  1,            1};
        tbl[5] = '{16'd3,     4'd6,  RND ? 2 : 1,  2};
        tbl[6] = '{16'd15,    4'd7,  RND ? 4 : 3,  6};
        tbl[7] = '{16'd240,   4'd8,  15,           15};
        tbl[8] = '{16'd65280, 4'd9,  255,          255};
        tbl[9] = '{16'd1,     4'd10, 1,            0};

        for (int i = 0; i < 10; i++) begin
            op_a(tbl[i].rad, tbl[i].tag, ra, ma, tg, lat);
            check($sformatf("tbl%0d_root", i), ra, tbl[i].root);
            check($sformatf("tbl%0d_rem", i), ma, tbl[i].rem);
            check($sformatf("tbl%0d_tag", i), tg, tbl[i].tag);
            check($sformatf("tbl%0d_lat", i), lat, LAT_A);
        end

        op_b(16'd2, 4'd11, rb, mb, tg, lat);
        check("frac_2_root", rb, RND ? 23 : 22);
        check("frac_2_rem", mb, 28);
        check("frac_2_tag", tg, 11);
        check("frac_2_lat", lat, LAT_B);
        op_b(16'd65535, 4'd12, rb, mb, tg, lat);
        check("frac_max_root", rb, 4095);
        check("frac_max_rem", mb, 7935);
        op_b(16'd0, 4'd13, rb, mb, tg, lat);
        check("frac_0_root", rb, 0);
        check("frac_0_rem", mb, 0);
        op_b(16'd1, 4'd14, rb, mb, tg, lat);
        check("frac_1_root", rb, 16);
        check("frac_1_rem", mb, 0);

        stream_a("bp", 10, 1'b0, 11, 16);
        stream_a("rnd", 10000, 1'b1, 0, 0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ifa.out_ready = 1'b0;
            ifa.in_valid  = 1'b1;
            ifa.radicand  = 16'(100 + i);
            ifa.in_tag    = 4'(i);
        end
        @(negedge clk);
        ifa.in_valid = 1'b0;
        repeat (20) begin
            if (ifa.out_valid) break;
            @(negedge clk);
        end
        check("rst_mid_pre_valid", ifa.out_valid, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_valid", ifa.out_valid, 0);
        check("rst_mid_root", ifa.root, 0);
        check("rst_mid_rem", ifa.remainder, 0);
        check("rst_mid_tag", ifa.out_tag, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ifa.out_ready = 1'b1;
        stale = 0;
        repeat (20) begin
            @(negedge clk);
            if (ifa.out_valid) stale++;
        end
        check("rst_no_stale", stale, 0);
        op_a(16'd49, 4'd7, ra, ma, tg, lat);
        check("rst_after_root", ra, 7);
        check("rst_after_rem", ma, 0);
        check("rst_after_tag", tg, 7);
        check("rst_after_lat", lat, LAT_A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
